// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    // One pending-write bit per register at the default depth.
    typedef logic [DEPTH_DEF-1:0] regfile_busy_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a bit vector.
module popcount #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 4
) (
    input  logic [IN_W-1:0]  vec,
    output logic [OUT_W-1:0] cnt_c
);

    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < IN_W; i++) begin
            cnt_c = cnt_c + OUT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read1Addr,
    input  logic [ADDR_W-1:0] read2Addr,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic              readRdy1,
    output logic              readRdy2,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic              rsvEn,
    input  logic [ADDR_W-1:0] rsvAddr,
    output logic              rsvOk,
    output logic [ADDR_W:0]   busyCnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit          ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt_c;
    logic [CNT_W-1:0]  cnt_nxt_c;
    logic              wr_ok_c;
    logic              rsv_set_c;
    logic              byp1_c;
    logic              byp2_c;

    // Register 0 is hardwired when ZERO_REG is set: no writes, no reservations.
    assign wr_ok_c   = wrEn & ~(ZR && (writeAddr == '0));
    assign rsvOk     = rsvEn & ~busy[rsvAddr];
    assign rsv_set_c = rsvOk & ~(ZR && (rsvAddr == '0));

    // Reservation is applied after the write clear so a new producer wins.
    always_comb begin
        busy_nxt_c = busy;
        if (wr_ok_c) begin
            busy_nxt_c[writeAddr] = 1'b0;
        end
        if (rsv_set_c) begin
            busy_nxt_c[rsvAddr] = 1'b1;
        end
    end

    popcount #(
        .IN_W  (DEPTH),
        .OUT_W (CNT_W)
    ) u_popcount (
        .vec   (busy_nxt_c),
        .cnt_c (cnt_nxt_c)
    );

`ifdef REGFILE_BYPASS_EN
    assign byp1_c = wr_ok_c && (writeAddr == read1Addr);
    assign byp2_c = wr_ok_c && (writeAddr == read2Addr);
`else
    assign byp1_c = 1'b0;
    assign byp2_c = 1'b0;
`endif

    always_comb begin
        readData1 = mem[read1Addr];
        readRdy1  = ~busy[read1Addr];
        if (ZR && (read1Addr == '0)) begin
            readData1 = '0;
            readRdy1  = 1'b1;
        end else if (byp1_c) begin
            readData1 = writeData;
            readRdy1  = 1'b1;
        end
    end

    always_comb begin
        readData2 = mem[read2Addr];
        readRdy2  = ~busy[read2Addr];
        if (ZR && (read2Addr == '0)) begin
            readData2 = '0;
            readRdy2  = 1'b1;
        end else if (byp2_c) begin
            readData2 = writeData;
            readRdy2  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            if (wr_ok_c) begin
                mem[writeAddr] <= writeData;
            end
            busy    <= busy_nxt_c;
            busyCnt <= cnt_nxt_c;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: two instances (ZERO_REG=0 and 1) share stimulus
// and are compared against a behavioural register/scoreboard model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  read1Addr, read2Addr, writeAddr, rsvAddr;
    logic [11:0] writeData;
    logic        wrEn, rsvEn;

    logic [11:0] rdata1 [2];
    logic [11:0] rdata2 [2];
    logic        rrdy1  [2];
    logic        rrdy2  [2];
    logic        rsvok  [2];
    logic [3:0]  bcnt   [2];

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    // Reference state per instance
    logic [11:0] m_mem  [2][8];
    bit          m_busy [2][8];
    int          m_cnt  [2];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(12), .ADDR_W(3), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .read1Addr(read1Addr), .read2Addr(read2Addr),
        .readData1(rdata1[0]), .readData2(rdata2[0]),
        .readRdy1(rrdy1[0]), .readRdy2(rrdy2[0]),
        .wrEn(wrEn), .writeAddr(writeAddr), .writeData(writeData),
        .rsvEn(rsvEn), .rsvAddr(rsvAddr), .rsvOk(rsvok[0]),
        .busyCnt(bcnt[0])
    );

    regfile_sb #(.DATA_W(12), .ADDR_W(3), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .read1Addr(read1Addr), .read2Addr(read2Addr),
        .readData1(rdata1[1]), .readData2(rdata2[1]),
        .readRdy1(rrdy1[1]), .readRdy2(rrdy2[1]),
        .wrEn(wrEn), .writeAddr(writeAddr), .writeData(writeData),
        .rsvEn(rsvEn), .rsvAddr(rsvAddr), .rsvOk(rsvok[1]),
        .busyCnt(bcnt[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {ready, data} for a read of address a on instance z
    function automatic logic [12:0] exp_read(input int z, input logic [2:0] a);
        if (z == 1 && a == 3'd0) return {1'b1, 12'h000};
`ifdef REGFILE_BYPASS_EN
        if (wrEn && a == writeAddr) return {1'b1, writeData};
`endif
        return {~m_busy[z][a], m_mem[z][a]};
    endfunction

    task automatic check_comb();
        logic [12:0] e1, e2;
        for (int z = 0; z < 2; z++) begin
            e1 = exp_read(z, read1Addr);
            e2 = exp_read(z, read2Addr);
            check($sformatf("rd1_data[%0d]", z), 32'(rdata1[z]), 32'(e1[11:0]));
            check($sformatf("rd1_rdy[%0d]", z), 32'(rrdy1[z]), 32'(e1[12]));
            check($sformatf("rd2_data[%0d]", z), 32'(rdata2[z]), 32'(e2[11:0]));
            check($sformatf("rd2_rdy[%0d]", z), 32'(rrdy2[z]), 32'(e2[12]));
            check($sformatf("rsv_ok[%0d]", z), 32'(rsvok[z]),
                  32'(rsvEn && !m_busy[z][rsvAddr]));
        end
    endtask

    task automatic model_edge();
        bit ok;
        for (int z = 0; z < 2; z++) begin
            if (!rst_n) begin
                for (int i = 0; i < 8; i++) begin
                    m_mem[z][i]  = 12'h000;
                    m_busy[z][i] = 1'b0;
                end
            end else begin
                ok = rsvEn && !m_busy[z][rsvAddr];
                if (wrEn && !(z == 1 && writeAddr == 3'd0)) begin
                    m_mem[z][writeAddr]  = writeData;
                    m_busy[z][writeAddr] = 1'b0;
                end
                if (ok && !(z == 1 && rsvAddr == 3'd0)) m_busy[z][rsvAddr] = 1'b1;
            end
            m_cnt[z] = 0;
            for (int i = 0; i < 8; i++) m_cnt[z] += int'(m_busy[z][i]);
        end
    endtask

    // One clock: check combinational outputs, clock, update model, check busyCnt
    task automatic step(input bit comb_chk);
        #1;
        if (comb_chk) check_comb();
        @(posedge clk);
        model_edge();
        #1;
        for (int z = 0; z < 2; z++)
            check($sformatf("busy_cnt[%0d]", z), 32'(bcnt[z]), 32'(m_cnt[z]));
    endtask

    task automatic set_in(input bit we, input int wa, input int wd,
                          input bit re, input int ra, input int a1, input int a2);
        wrEn      = we;
        writeAddr = 3'(wa);
        writeData = 12'(wd);
        rsvEn     = re;
        rsvAddr   = 3'(ra);
        read1Addr = 3'(a1);
        read2Addr = 3'(a2);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        step(0);
        rst_n = 1'b1;

        // Reset state: everything reads 0 / ready
        for (int a = 0; a < 8; a++) begin
            set_in(0, 0, 0, 0, 0, a, 7 - a);
            #1 check("reset_data", 32'(rdata1[0]), 32'h0);
            check("reset_rdy", 32'(rrdy1[0]), 32'h1);
            step(1);
        end
        check("reset_cnt", 32'(bcnt[0]), 32'h0);

        // Basic write then read
        set_in(1, 5, 12'hABC, 0, 0, 5, 5);
        step(1);
        set_in(0, 0, 0, 0, 0, 5, 0);
        #1 check("wr5_data", 32'(rdata1[0]), 32'hABC);
        check("wr5_rdy", 32'(rrdy1[0]), 32'h1);
        step(1);

        // Scoreboard reserve / reject / release
        set_in(0, 0, 0, 1, 3, 0, 3);
        #1 check("rsv3_ok", 32'(rsvok[0]), 32'h1);
        step(1);
        check("rsv3_cnt", 32'(bcnt[0]), 32'h1);
        set_in(0, 0, 0, 1, 3, 0, 3);
        #1 check("rsv3_rdy", 32'(rrdy2[0]), 32'h0);
        check("rsv3_again", 32'(rsvok[0]), 32'h0);
        step(1);
        check("rsv3_cnt_hold", 32'(bcnt[0]), 32'h1);
        set_in(1, 3, 12'h123, 0, 0, 3, 3);
        step(1);
        set_in(0, 0, 0, 0, 0, 3, 3);
        #1 check("rel3_data", 32'(rdata1[0]), 32'h123);
        check("rel3_rdy", 32'(rrdy1[0]), 32'h1);
        check("rel3_cnt", 32'(bcnt[0]), 32'h0);
        step(1);

        // Simultaneous write and reservation on a busy register
        set_in(0, 0, 0, 1, 4, 4, 4);
        step(1);
        set_in(1, 4, 12'h055, 1, 4, 4, 4);
        #1 check("sim4_rsv_rej", 32'(rsvok[0]), 32'h0);
        step(1);
        set_in(0, 0, 0, 0, 0, 4, 4);
        #1 check("sim4_rdy", 32'(rrdy1[0]), 32'h1);
        check("sim4_data", 32'(rdata1[0]), 32'h055);
        check("sim4_cnt", 32'(bcnt[0]), 32'h0);
        step(1);
        set_in(1, 6, 12'h666, 1, 4, 4, 6);
        #1 check("rsv4_w6_ok", 32'(rsvok[0]), 32'h1);
        step(1);
        set_in(0, 0, 0, 0, 0, 4, 6);
        #1 check("rsv4_w6_rdy", 32'(rrdy1[0]), 32'h0);
        step(1);

        // Register 0 hardwired on the ZERO_REG instance
        set_in(1, 0, 12'hFFF, 0, 0, 0, 0);
        step(1);
        set_in(0, 0, 0, 1, 0, 0, 0);
        #1 check("zr_data", 32'(rdata1[1]), 32'h0);
        check("nzr_data", 32'(rdata1[0]), 32'hFFF);
        check("zr_rsv_ok", 32'(rsvok[1]), 32'h1);
        step(1);
        check("zr_cnt", 32'(bcnt[1]), 32'h1);
        check("nzr_cnt", 32'(bcnt[0]), 32'h2);

        // Write while reading the same address
        set_in(1, 2, 12'h777, 0, 0, 2, 2);
`ifdef REGFILE_BYPASS_EN
        #1 check("byp_same", 32'(rdata1[0]), 32'h777);
`else
        #1 check("nobyp_same", 32'(rdata1[0]), 32'h000);
`endif
        step(1);
        set_in(0, 0, 0, 0, 0, 2, 2);
        #1 check("byp_next", 32'(rdata1[0]), 32'h777);
        step(1);

        // Reservations cleared by mid-run reset
        set_in(0, 0, 0, 1, 1, 1, 2); step(1);
        set_in(0, 0, 0, 1, 2, 1, 2); step(1);
        set_in(0, 0, 0, 1, 7, 1, 7); step(1);
        rst_n = 1'b0;
        set_in(1, 5, 12'h5A5, 1, 5, 1, 7);
        step(1);
        rst_n = 1'b1;
        check("rst_cnt0", 32'(bcnt[0]), 32'h0);
        check("rst_cnt1", 32'(bcnt[1]), 32'h0);
        for (int a = 0; a < 8; a++) begin
            set_in(0, 0, 0, 0, 0, a, a);
            #1 check("rst_rdy", 32'(rrdy1[0]), 32'h1);
            step(1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            set_in(1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)));
            step(1);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
